llki_mock_tss_keyed: RTL and testbench

//  Parametrised mock technique-specific shim (TSS) placed in front of any CEP core datapath input.

---
 rtl/llki_mock_tss_keyed.sv | 108 ++++++++++
 tb/tb_llki_mock_tss_keyed.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/llki_mock_tss_keyed.sv
// llki_mock_tss_keyed: mock TSS that loads a key over LLKI and XORs the folded key mask into the core input.
// Define LLKI_START_GATE_EN to hold core_start_o low until the key is loaded.
module llki_mock_tss_keyed #(
    parameter int DATA_WIDTH = 128,
    parameter int KEY_WORDS = 3,
    parameter logic [KEY_WORDS*64-1:0] EXP_KEY = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  llki_req_valid,
    output logic                  llki_req_ready,
    input  logic [1:0]            llki_req_op,
    input  logic [63:0]           llki_req_data,
    output logic                  llki_rsp_valid,
    input  logic                  llki_rsp_ready,
    output logic [1:0]            llki_rsp_status,
    output logic                  key_loaded,
    output logic                  key_match,
    input  logic [DATA_WIDTH-1:0] core_in_i,
    output logic [DATA_WIDTH-1:0] core_in_o,
    input  logic                  core_start_i,
    output logic                  core_start_o
);
    localparam int NS = DATA_WIDTH / 64;
    localparam int CW = 4;
    localparam logic [1:0] OP_LOAD = 2'b00, OP_CLEAR = 2'b01, OP_STATUS = 2'b10;
    localparam logic [1:0] ST_OK = 2'b00, ST_ERR_STATE = 2'b01, ST_ERR_OP = 2'b10;

    typedef enum logic [1:0] {IDLE, LOAD, KEYED} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [KEY_WORDS*64-1:0] key_q, key_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [1:0]              status_q, status_d;
    logic                    key_loaded_q, key_match_q;
    logic [DATA_WIDTH-1:0]   mask;
    logic                    acc;

    assign acc = llki_req_valid & ~rsp_valid_q;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        key_d = key_q;
        rsp_valid_d = rsp_valid_q & ~llki_rsp_ready;
        status_d = status_q;
        if (acc) begin
            rsp_valid_d = 1'b1;
            status_d = ST_OK;
            case (llki_req_op)
                OP_LOAD:
                    if (state_q == KEYED) status_d = ST_ERR_STATE;
                    else begin
                        key_d[64*cnt_q +: 64] = llki_req_data;
                        cnt_d = cnt_q + 1'b1;
                        state_d = (cnt_d == CW'(KEY_WORDS)) ? KEYED : LOAD;
                    end
                OP_CLEAR: begin
                    key_d = '0;
                    cnt_d = '0;
                    state_d = IDLE;
                end
                OP_STATUS: ;
                default: status_d = ST_ERR_OP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            key_q <= '0;
            rsp_valid_q <= 1'b0;
            status_q <= ST_OK;
            key_loaded_q <= 1'b0;
            key_match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            key_q <= key_d;
            rsp_valid_q <= rsp_valid_d;
            status_q <= status_d;
            key_loaded_q <= state_d == KEYED;
            key_match_q <= (state_d == KEYED) && (key_d == EXP_KEY);
        end
    end

    // Key words beyond the data width fold onto slice i mod NS.
    always_comb begin
        mask = '0;
        for (int i = 0; i < KEY_WORDS; i++)
            mask[64*(i%NS) +: 64] = mask[64*(i%NS) +: 64] ^ EXP_KEY[64*i +: 64] ^ key_q[64*i +: 64];
    end

    assign core_in_o = core_in_i ^ mask;
    assign llki_req_ready = ~rsp_valid_q;
    assign llki_rsp_valid = rsp_valid_q;
    assign llki_rsp_status = status_q;
    assign key_loaded = key_loaded_q;
    assign key_match = key_match_q;
`ifdef LLKI_START_GATE_EN
    assign core_start_o = core_start_i & key_loaded_q;
`else
    assign core_start_o = core_start_i;
`endif
endmodule

// File: tb/tb_llki_mock_tss_keyed.sv
// tb_llki_mock_tss_keyed: directed bench for the keyed mock TSS (128-bit data, 3 key words).
module tb_llki_mock_tss_keyed;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         llki_req_valid = 1'b0;
    logic         llki_req_ready;
    logic [1:0]   llki_req_op = 2'b00;
    logic [63:0]  llki_req_data = '0;
    logic         llki_rsp_valid;
    logic         llki_rsp_ready = 1'b0;
    logic [1:0]   llki_rsp_status;
    logic         key_loaded, key_match;
    logic [127:0] core_in_i = '0;
    logic [127:0] core_in_o;
    logic         core_start_i = 1'b0;
    logic         core_start_o;
    int checks = 0;
    int errors = 0;

    localparam logic [127:0] PAT = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [127:0] MASK_EMPTY = {64'h2, 64'h5};
    localparam logic [127:0] MASK_W0 = {64'h2, 64'h4};

    llki_mock_tss_keyed #(
        .DATA_WIDTH(128),
        .KEY_WORDS(3),
        .EXP_KEY({64'h4, 64'h2, 64'h1})
    ) dut (
        .clk(clk), .rst(rst),
        .llki_req_valid(llki_req_valid), .llki_req_ready(llki_req_ready),
        .llki_req_op(llki_req_op), .llki_req_data(llki_req_data),
        .llki_rsp_valid(llki_rsp_valid), .llki_rsp_ready(llki_rsp_ready),
        .llki_rsp_status(llki_rsp_status),
        .key_loaded(key_loaded), .key_match(key_match),
        .core_in_i(core_in_i), .core_in_o(core_in_o),
        .core_start_i(core_start_i), .core_start_o(core_start_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [63:0] d, input logic [1:0] exp_st);
        int n;
        llki_req_valid = 1'b1;
        llki_req_op = op;
        llki_req_data = d;
        n = 0;
        while (!llki_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", 128'(llki_req_ready), 128'(1));
        @(negedge clk);
        llki_req_valid = 1'b0;
        chk("rsp_valid_set", 128'(llki_rsp_valid), 128'(1));
        chk("rsp_status", 128'(llki_rsp_status), 128'(exp_st));
        llki_rsp_ready = 1'b1;
        @(negedge clk);
        llki_rsp_ready = 1'b0;
        chk("rsp_valid_clr", 128'(llki_rsp_valid), 128'(0));
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_start(input logic exp_gated);
        core_start_i = 1'b1;
        #1;
`ifdef LLKI_START_GATE_EN
        chk("core_start", 128'(core_start_o), 128'(exp_gated));
`else
        chk("core_start", 128'(core_start_o), 128'(exp_gated | 1'b1));
`endif
        core_start_i = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        // reset state and scrambled pass-through with empty key
        chk("rst_rsp_valid", 128'(llki_rsp_valid), 128'(0));
        chk("rst_status", 128'(llki_rsp_status), 128'(0));
        chk("rst_key_loaded", 128'(key_loaded), 128'(0));
        chk("rst_key_match", 128'(key_match), 128'(0));
        chk("rst_req_ready", 128'(llki_req_ready), 128'(1));
        #1 chk("mask_empty_zero", core_in_o, MASK_EMPTY);
        core_in_i = PAT;
        #1 chk("mask_empty_pat", core_in_o, PAT ^ MASK_EMPTY);
        check_start(1'b0);
        @(negedge clk);
        // correct key load
        send(2'b00, 64'h1, 2'b00);
        chk("w0_key_loaded", 128'(key_loaded), 128'(0));
        chk("w0_mask", core_in_o, PAT ^ MASK_W0);
        send(2'b00, 64'h2, 2'b00);
        send(2'b00, 64'h4, 2'b00);
        chk("keyed_loaded", 128'(key_loaded), 128'(1));
        chk("keyed_match", 128'(key_match), 128'(1));
        chk("keyed_clean", core_in_o, PAT);
        check_start(1'b1);
        // errors while keyed
        send(2'b00, 64'hDEAD, 2'b01);
        chk("err_state_match", 128'(key_match), 128'(1));
        chk("err_state_clean", core_in_o, PAT);
        send(2'b11, 64'h0, 2'b10);
        send(2'b10, 64'h0, 2'b00);
        chk("status_loaded", 128'(key_loaded), 128'(1));
        // clear, then clear again in IDLE
        send(2'b01, 64'h0, 2'b00);
        chk("clear_loaded", 128'(key_loaded), 128'(0));
        chk("clear_mask", core_in_o, PAT ^ MASK_EMPTY);
        send(2'b01, 64'h0, 2'b00);
        chk("clear_idle_mask", core_in_o, PAT ^ MASK_EMPTY);
        // reset mid-load with a pending response
        send(2'b00, 64'h1, 2'b00);
        send(2'b00, 64'h2, 2'b00);
        llki_req_valid = 1'b1;
        llki_req_op = 2'b10;
        @(negedge clk);
        llki_req_valid = 1'b0;
        chk("pend_rsp_valid", 128'(llki_rsp_valid), 128'(1));
        pulse_rst();
        chk("midrst_rsp_valid", 128'(llki_rsp_valid), 128'(0));
        chk("midrst_loaded", 128'(key_loaded), 128'(0));
        chk("midrst_mask", core_in_o, PAT ^ MASK_EMPTY);
        send(2'b00, 64'h1, 2'b00);
        send(2'b00, 64'h2, 2'b00);
        send(2'b00, 64'h4, 2'b00);
        chk("reload_match", 128'(key_match), 128'(1));
        // wrong key still reaches KEYED
        send(2'b01, 64'h0, 2'b00);
        send(2'b00, 64'h1, 2'b00);
        send(2'b00, 64'h2, 2'b00);
        send(2'b00, 64'h5, 2'b00);
        chk("wrong_loaded", 128'(key_loaded), 128'(1));
        chk("wrong_match", 128'(key_match), 128'(0));
        chk("wrong_mask", core_in_o, PAT ^ {64'h0, 64'h1});
        // response back-pressure: held response, blocked request
        send(2'b01, 64'h0, 2'b00);
        llki_req_valid = 1'b1;
        llki_req_op = 2'b00;
        llki_req_data = 64'h1;
        @(negedge clk);
        llki_req_op = 2'b01;
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_valid", 128'(llki_rsp_valid), 128'(1));
            chk("hold_status", 128'(llki_rsp_status), 128'(0));
            chk("hold_req_ready", 128'(llki_req_ready), 128'(0));
            chk("hold_mask", core_in_o, PAT ^ MASK_W0);
            @(negedge clk);
        end
        llki_req_valid = 1'b0;
        llki_rsp_ready = 1'b1;
        @(negedge clk);
        llki_rsp_ready = 1'b0;
        chk("hold_release", 128'(llki_rsp_valid), 128'(0));
        chk("hold_after_mask", core_in_o, PAT ^ MASK_W0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
